coherence_bus_sequencer: RTL and testbench

- Round-robin arbiter and transaction sequencer for the shared MESI coherence bus between the per-CPU L1 data caches and L2.
- Grants one requester at a time and broadcasts a snoop to all other caches.
- Collects snoop responses, then services the miss with one of two paths:
  - dirty-hit: cache-to-cache forward plus L2 writeback;
  - no dirty hit: L2 read.
- Tells the requester whether it may install the line EXCLUSIVE.

---
 rtl/coherence_bus_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_coherence_bus_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_sequencer.sv
// rtl/coherence_bus_sequencer.sv - round-robin MESI bus arbiter with snoop collection and L2 read/writeback sequencing
module coherence_bus_sequencer #(
  parameter int CPUS       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [CPUS-1:0]            req_valid,
  input  logic [CPUS-1:0]            req_write,
  input  logic [CPUS*ADDR_WIDTH-1:0] req_addr,
  output logic [CPUS-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]      req_rdata,
  output logic                       req_exclusive,
  output logic [CPUS-1:0]            grant,
  output logic                       busy,
  output logic                       snoop_valid,
  output logic [ADDR_WIDTH-1:0]      snoop_addr,
  output logic                       snoop_inv,
  output logic [CPUS-1:0]            snoop_mask,
  input  logic [CPUS-1:0]            snoop_done,
  input  logic [CPUS-1:0]            snoop_hit,
  input  logic [CPUS-1:0]            snoop_dirty,
  input  logic [CPUS*DATA_WIDTH-1:0] snoop_data,
  output logic                       l2_ren,
  output logic                       l2_wen,
  output logic [ADDR_WIDTH-1:0]      l2_addr,
  output logic [DATA_WIDTH-1:0]      l2_wdata,
  input  logic [DATA_WIDTH-1:0]      l2_rdata,
  input  logic                       l2_ready
);
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [2:0] {IDLE, SNOOP, L2RD, WB, RESP} state_t;

  state_t                state;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         sup_idx;
  logic                  win_found;
  logic [CPUS-1:0]       win_oh;
  logic [CPUS-1:0]       acc_done, acc_hit, acc_dirty;
  logic [CPUS-1:0]       new_done, done_n, hit_n, dirty_n;
  logic [DATA_WIDTH-1:0] acc_data [CPUS];
  logic [DATA_WIDTH-1:0] data_n   [CPUS];
  logic [DATA_WIDTH-1:0] sdata    [CPUS];
  logic [ADDR_WIDTH-1:0] addr_arr [CPUS];
  logic                  any_hit;
  logic                  snoop_complete;
  int                    j;

  // Only the first done seen from each snooper is captured; later toggles are ignored.
  assign new_done       = snoop_done & snoop_mask & ~acc_done;
  assign done_n         = acc_done | new_done;
  assign hit_n          = acc_hit | (snoop_hit & new_done);
  assign dirty_n        = acc_dirty | (snoop_dirty & new_done);
  assign snoop_complete = &(done_n | grant);

  always_comb begin
    for (int i = 0; i < CPUS; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      sdata[i]    = snoop_data[i*DATA_WIDTH +: DATA_WIDTH];
      data_n[i]   = new_done[i] ? sdata[i] : acc_data[i];
    end
  end

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 1; k <= CPUS; k++) begin
      j = int'(last_grant) + k;
      if (j >= CPUS) j = j - CPUS;
      if (!win_found && req_valid[IW'(j)]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    sup_idx = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (dirty_n[i]) sup_idx = IW'(i);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      last_grant    <= IW'(CPUS - 1);
      grant         <= '0;
      busy          <= 1'b0;
      snoop_valid   <= 1'b0;
      snoop_addr    <= '0;
      snoop_inv     <= 1'b0;
      snoop_mask    <= '0;
      acc_done      <= '0;
      acc_hit       <= '0;
      acc_dirty     <= '0;
      any_hit       <= 1'b0;
      l2_ren        <= 1'b0;
      l2_wen        <= 1'b0;
      l2_addr       <= '0;
      l2_wdata      <= '0;
      req_ready     <= '0;
      req_rdata     <= '0;
      req_exclusive <= 1'b0;
      for (int i = 0; i < CPUS; i++) acc_data[i] <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= SNOOP;
            grant       <= win_oh;
            last_grant  <= win_idx;
            snoop_addr  <= addr_arr[win_idx];
            snoop_inv   <= req_write[win_idx];
            busy        <= 1'b1;
            snoop_valid <= 1'b1;
            snoop_mask  <= ~win_oh;
          end
        end
        SNOOP: begin
          acc_done  <= done_n;
          acc_hit   <= hit_n;
          acc_dirty <= dirty_n;
          for (int i = 0; i < CPUS; i++) acc_data[i] <= data_n[i];
          if (snoop_complete) begin
            snoop_valid <= 1'b0;
            snoop_mask  <= '0;
            acc_done    <= '0;
            acc_hit     <= '0;
            acc_dirty   <= '0;
            any_hit     <= |hit_n;
            l2_addr     <= snoop_addr;
            if (|dirty_n) begin
              state    <= WB;
              l2_wen   <= 1'b1;
              l2_wdata <= data_n[sup_idx];
            end else begin
              state  <= L2RD;
              l2_ren <= 1'b1;
            end
          end
        end
        L2RD: begin
          if (l2_ready) begin
            state         <= RESP;
            l2_ren        <= 1'b0;
            l2_addr       <= '0;
            req_ready     <= grant;
            req_rdata     <= l2_rdata;
            req_exclusive <= snoop_inv | ~any_hit;
          end
        end
        WB: begin
          if (l2_ready) begin
            state         <= RESP;
            l2_wen        <= 1'b0;
            l2_addr       <= '0;
            l2_wdata      <= '0;
            req_ready     <= grant;
            req_rdata     <= l2_wdata;
            req_exclusive <= snoop_inv | ~any_hit;
          end
        end
        RESP: begin
          state         <= IDLE;
          grant         <= '0;
          busy          <= 1'b0;
          snoop_addr    <= '0;
          snoop_inv     <= 1'b0;
          any_hit       <= 1'b0;
          req_rdata     <= '0;
          req_exclusive <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coherence_bus_sequencer.sv
// tb/tb_coherence_bus_sequencer.sv - directed self-checking bench for coherence_bus_sequencer (CPUS=2 and CPUS=4)
module tb_coherence_bus_sequencer;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  int          total = 0;
  int          bad = 0;

  logic [1:0]  req_valid, req_write, req_ready, grant, snoop_mask;
  logic [1:0]  snoop_done, snoop_hit, snoop_dirty;
  logic [63:0] req_addr, snoop_data;
  logic [31:0] req_rdata, snoop_addr, l2_addr, l2_wdata, l2_rdata;
  logic        req_exclusive, busy, snoop_valid, snoop_inv, l2_ren, l2_wen, l2_ready;

  logic [3:0]   req_valid_4, req_write_4, req_ready_4, grant_4, snoop_mask_4;
  logic [3:0]   snoop_done_4, snoop_hit_4, snoop_dirty_4;
  logic [127:0] req_addr_4, snoop_data_4;
  logic [31:0]  req_rdata_4, snoop_addr_4, l2_addr_4, l2_wdata_4, l2_rdata_4;
  logic         req_exclusive_4, busy_4, snoop_valid_4, snoop_inv_4, l2_ren_4, l2_wen_4, l2_ready_4;

  always #5 CLK = ~CLK;

  coherence_bus_sequencer #(.CPUS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_exclusive(req_exclusive), .grant(grant),
    .busy(busy), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_inv(snoop_inv),
    .snoop_mask(snoop_mask), .snoop_done(snoop_done), .snoop_hit(snoop_hit),
    .snoop_dirty(snoop_dirty), .snoop_data(snoop_data), .l2_ren(l2_ren), .l2_wen(l2_wen),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_ready(l2_ready)
  );

  coherence_bus_sequencer #(.CPUS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut4 (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid_4), .req_write(req_write_4), .req_addr(req_addr_4),
    .req_ready(req_ready_4), .req_rdata(req_rdata_4), .req_exclusive(req_exclusive_4), .grant(grant_4),
    .busy(busy_4), .snoop_valid(snoop_valid_4), .snoop_addr(snoop_addr_4), .snoop_inv(snoop_inv_4),
    .snoop_mask(snoop_mask_4), .snoop_done(snoop_done_4), .snoop_hit(snoop_hit_4),
    .snoop_dirty(snoop_dirty_4), .snoop_data(snoop_data_4), .l2_ren(l2_ren_4), .l2_wen(l2_wen_4),
    .l2_addr(l2_addr_4), .l2_wdata(l2_wdata_4), .l2_rdata(l2_rdata_4), .l2_ready(l2_ready_4)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0;
    snoop_done = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
    l2_rdata = '0; l2_ready = 1'b0;
    req_valid_4 = '0; req_write_4 = '0; req_addr_4 = '0;
    snoop_done_4 = '0; snoop_hit_4 = '0; snoop_dirty_4 = '0; snoop_data_4 = '0;
    l2_rdata_4 = '0; l2_ready_4 = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    total++; if (snoop_valid !== 1'b0 || snoop_mask !== 2'b00) begin bad++; $display("FAIL rst_snoop got=%b/%b exp=0/00", snoop_valid, snoop_mask); end
    total++; if (l2_ren !== 1'b0 || l2_wen !== 1'b0) begin bad++; $display("FAIL rst_l2 got=%b%b exp=00", l2_ren, l2_wen); end
    total++; if (grant_4 !== 4'b0000 || busy_4 !== 1'b0) begin bad++; $display("FAIL rst_dut4 got=%b/%b exp=0000/0", grant_4, busy_4); end
  endtask

  task automatic test_busrd_miss();
    req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h100};
    snoop_done = 2'b10; l2_ready = 1'b1; l2_rdata = 32'hDEADBEEF;
    tick();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL t1_grant got=%b exp=01", grant); end
    total++; if (snoop_valid !== 1'b1 || snoop_mask !== 2'b10) begin bad++; $display("FAIL t1_snoop got=%b/%b exp=1/10", snoop_valid, snoop_mask); end
    total++; if (snoop_addr !== 32'h100 || snoop_inv !== 1'b0) begin bad++; $display("FAIL t1_saddr got=%h/%b exp=100/0", snoop_addr, snoop_inv); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", busy); end
    tick();
    total++; if (l2_ren !== 1'b1 || l2_wen !== 1'b0 || l2_addr !== 32'h100) begin bad++; $display("FAIL t1_l2rd got=%b%b %h exp=10 100", l2_ren, l2_wen, l2_addr); end
    tick();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t1_ready got=%b exp=01", req_ready); end
    total++; if (req_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_rdata got=%h exp=deadbeef", req_rdata); end
    total++; if (req_exclusive !== 1'b1) begin bad++; $display("FAIL t1_excl got=%b exp=1", req_exclusive); end
    clear_inputs();
    tick();
    total++; if (grant !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin bad++; $display("FAIL t1_idle got=%b/%b/%b exp=00/0/00", grant, busy, req_ready); end
    tick();
  endtask

  task automatic test_clean_hit();
    req_valid = 2'b10; req_addr = {32'h200, 32'h0};
    snoop_done = 2'b01; snoop_hit = 2'b01; l2_ready = 1'b1; l2_rdata = 32'h11112222;
    tick();
    total++; if (grant !== 2'b10 || snoop_mask !== 2'b01) begin bad++; $display("FAIL t2_grant got=%b/%b exp=10/01", grant, snoop_mask); end
    tick();
    total++; if (l2_ren !== 1'b1 || l2_wen !== 1'b0 || l2_addr !== 32'h200) begin bad++; $display("FAIL t2_l2rd got=%b%b %h exp=10 200", l2_ren, l2_wen, l2_addr); end
    tick();
    total++; if (req_ready !== 2'b10 || req_rdata !== 32'h11112222) begin bad++; $display("FAIL t2_resp got=%b %h exp=10 11112222", req_ready, req_rdata); end
    total++; if (req_exclusive !== 1'b0) begin bad++; $display("FAIL t2_excl got=%b exp=0", req_exclusive); end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_dirty_forward();
    req_valid = 2'b01; req_write = 2'b01; req_addr = {32'h0, 32'h300};
    snoop_done = 2'b10; snoop_hit = 2'b10; snoop_dirty = 2'b10; snoop_data = {32'hCAFEF00D, 32'h0};
    l2_ready = 1'b1; l2_rdata = 32'h55555555;
    tick();
    total++; if (grant !== 2'b01 || snoop_inv !== 1'b1) begin bad++; $display("FAIL t3_inv got=%b/%b exp=01/1", grant, snoop_inv); end
    tick();
    total++; if (l2_wen !== 1'b1 || l2_ren !== 1'b0) begin bad++; $display("FAIL t3_wen got=%b%b exp=01", l2_ren, l2_wen); end
    total++; if (l2_addr !== 32'h300 || l2_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL t3_wb got=%h %h exp=300 cafef00d", l2_addr, l2_wdata); end
    tick();
    total++; if (req_ready !== 2'b01 || req_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL t3_resp got=%b %h exp=01 cafef00d", req_ready, req_rdata); end
    total++; if (req_exclusive !== 1'b1) begin bad++; $display("FAIL t3_excl got=%b exp=1", req_exclusive); end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] seen [4];
    int         at [4];
    int         n = 0;
    clear_inputs();
    do_reset();
    req_valid = 2'b11; req_addr = {32'hB00, 32'hA00};
    snoop_done = 2'b11; l2_ready = 1'b1; l2_rdata = 32'h0BAD0BAD;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      if (req_ready !== 2'b00) begin
        seen[n] = req_ready;
        at[n] = c;
        n++;
      end
    end
    req_valid = 2'b00;
    total++; if (n != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      total++; if (seen[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL b2b_order%0d got=%b exp=%b", k, seen[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
    end
    if (n > 0) begin
      total++; if (at[0] != 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", at[0]); end
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_sticky_snoop4();
    req_valid_4 = 4'b0001; req_addr_4 = {96'h0, 32'h400};
    l2_ready_4 = 1'b1; l2_rdata_4 = 32'h44440000;
    tick();
    total++; if (grant_4 !== 4'b0001 || snoop_mask_4 !== 4'b1110) begin bad++; $display("FAIL t5_grant got=%b/%b exp=0001/1110", grant_4, snoop_mask_4); end
    snoop_done_4 = 4'b0010;
    tick();
    snoop_done_4 = 4'b0000;
    tick();
    snoop_done_4 = 4'b0100; snoop_hit_4 = 4'b0100;
    tick();
    snoop_done_4 = 4'b0000; snoop_hit_4 = 4'b0000;
    total++; if (snoop_valid_4 !== 1'b1) begin bad++; $display("FAIL t5_snoop_c4 got=%b exp=1", snoop_valid_4); end
    tick();
    snoop_done_4 = 4'b1000;
    total++; if (snoop_valid_4 !== 1'b1 || l2_ren_4 !== 1'b0) begin bad++; $display("FAIL t5_snoop_c5 got=%b/%b exp=1/0", snoop_valid_4, l2_ren_4); end
    tick();
    snoop_done_4 = 4'b0000;
    total++; if (l2_ren_4 !== 1'b1 || snoop_valid_4 !== 1'b0) begin bad++; $display("FAIL t5_l2rd got=%b/%b exp=1/0", l2_ren_4, snoop_valid_4); end
    tick();
    total++; if (req_ready_4 !== 4'b0001 || req_rdata_4 !== 32'h44440000) begin bad++; $display("FAIL t5_resp got=%b %h exp=0001 44440000", req_ready_4, req_rdata_4); end
    total++; if (req_exclusive_4 !== 1'b0) begin bad++; $display("FAIL t5_excl got=%b exp=0", req_exclusive_4); end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_reset_midflight();
    req_valid = 2'b10; req_addr = {32'h600, 32'h0};
    snoop_done = 2'b01; l2_ready = 1'b0;
    tick();
    tick();
    total++; if (l2_ren !== 1'b1) begin bad++; $display("FAIL t6_l2rd got=%b exp=1", l2_ren); end
    nRST = 1'b0;
    #1;
    total++; if (grant !== 2'b00 || busy !== 1'b0 || l2_ren !== 1'b0) begin bad++; $display("FAIL t6_async got=%b/%b/%b exp=00/0/0", grant, busy, l2_ren); end
    total++; if (snoop_addr !== 32'h0 || req_ready !== 2'b00) begin bad++; $display("FAIL t6_outs got=%h/%b exp=0/00", snoop_addr, req_ready); end
    clear_inputs();
    tick();
    nRST = 1'b1;
    tick();
    req_valid = 2'b11; req_addr = {32'h700, 32'h680}; snoop_done = 2'b11; l2_ready = 1'b1; l2_rdata = 32'h66;
    tick();
    total++; if (grant !== 2'b01 || snoop_addr !== 32'h680) begin bad++; $display("FAIL t6_prio got=%b %h exp=01 680", grant, snoop_addr); end
    tick();
    tick();
    total++; if (req_ready !== 2'b01 || req_rdata !== 32'h66) begin bad++; $display("FAIL t6_resp got=%b %h exp=01 66", req_ready, req_rdata); end
    clear_inputs();
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_busrd_miss();
    test_clean_hit();
    test_dirty_forward();
    test_back_to_back();
    test_sticky_snoop4();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
